// File: rtl/uart_tx_drain_if.sv
// Pop-side handshake between a first-word-fall-through FIFO and the UART drain.
// The FIFO side presents empty/r_data; the drain answers with a one-cycle rd strobe.
interface uart_tx_drain_if #(
  parameter int DBIT = 8
);
  logic            empty;
  logic [DBIT-1:0] r_data;
  logic            rd;

  modport master (output empty, output r_data, input rd);
  modport slave  (input empty, input r_data, output rd);
endinterface

// File: rtl/uart_tx_drain.sv
// Pops one word at a time from a FWFT FIFO and serialises it as start/data(LSB first)/stop.
// rd is combinational in IDLE; tx is registered and falls the cycle after the pop; no input is sampled mid-frame.
module uart_tx_drain #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_drain_if.slave fifo,
  output logic           tx,
  output logic           tx_busy
);
  localparam int TICK_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [DVSR_W-1:0] BAUD_LAST      = DVSR_W'(DVSR - 1);
  localparam logic [TICK_W-1:0] TICK_BIT_LAST  = TICK_W'(15);
  localparam logic [TICK_W-1:0] TICK_STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [DVSR_W-1:0] r_baud, w_baud_nxt;
  logic [TICK_W-1:0] r_tick, w_tick_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [DBIT-1:0]   r_shreg, w_shreg_nxt;
  logic              r_tx, w_tx_nxt;
  logic              w_s_tick;
  logic              w_pop;

  assign w_s_tick = (r_state != IDLE) && (r_baud == BAUD_LAST);
  assign w_pop    = (r_state == IDLE) && !fifo.empty && !reset;
  assign fifo.rd  = w_pop;
  assign tx       = r_tx;
  assign tx_busy  = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_tx_nxt    = 1'b1;

    if (r_state == IDLE || w_s_tick) begin
      w_baud_nxt = '0;
    end else begin
      w_baud_nxt = r_baud + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_state_nxt = START;
          w_shreg_nxt = fifo.r_data;
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      START: begin
        if (w_s_tick) begin
          if (r_tick == TICK_BIT_LAST) begin
            w_state_nxt = DATA;
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_s_tick) begin
          if (r_tick == TICK_BIT_LAST) begin
            w_tick_nxt  = '0;
            w_shreg_nxt = r_shreg >> 1;
            if (r_bit == BIT_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_s_tick) begin
          if (r_tick == TICK_STOP_LAST) begin
            w_state_nxt = IDLE;
            w_tick_nxt  = '0;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level is decoded from the upcoming state so tx moves on the same edge as the state.
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_drain.sv
// Randomised scoreboard bench: queued words are predicted as ideal line waveforms and checked
// cycle by cycle as the DUT serialises them; a second instance covers the two-stop-bit timing.
module tb_uart_tx_drain;
  localparam int DVSR   = 4;
  localparam int BITC   = 16 * DVSR;
  localparam int FRAME1 = 9 * BITC + 16 * DVSR;
  localparam int FRAME2 = 9 * BITC + 32 * DVSR;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx, tx_busy, tx2, tx_busy2;

  uart_tx_drain_if #(.DBIT(8)) ff_if();
  uart_tx_drain_if #(.DBIT(8)) ff2_if();

  uart_tx_drain #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_W(8)) dut (
    .clk(clk), .reset(reset), .fifo(ff_if), .tx(tx), .tx_busy(tx_busy)
  );

  uart_tx_drain #(.DBIT(8), .SB_TICK(32), .DVSR(DVSR), .DVSR_W(8)) dut2 (
    .clk(clk), .reset(reset), .fifo(ff2_if), .tx(tx2), .tx_busy(tx_busy2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  logic rd_seen    = 1'b0;
  logic reset_seen = 1'b1;
  int   rd_events = 0, frames_done = 0, aborted = 0, pushed = 0;
  int   missed_rd = 0, spurious_rd = 0, idle_bad = 0, rd_in_reset = 0, reset_state_bad = 0;
  bit   dut2_done = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Ideal line level k clocks after the pop cycle: start bit, 8 data bits LSB first, then stop.
  function automatic logic exp_tx(input logic [7:0] w, input int k);
    if (k <= BITC) return 1'b0;
    if (k <= 9 * BITC) return w[(k - BITC - 1) / BITC];
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] w);
    @(posedge clk);
    #2;
    fifo_q.push_back(w);
    exp_q.push_back(w);
    pushed++;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && tx_busy == 1'b0) done = 1;
    end
    if (!done) chk("wait_idle_timeout", 0, 1);
  endtask

  // FIFO model: FWFT head while the drain is idle, garbage on both inputs while a frame is in flight.
  initial begin : fifo_driver
    logic [7:0] tmp;
    ff_if.empty  = 1'b1;
    ff_if.r_data = 8'h00;
    forever begin
      @(posedge clk);
      if (rd_seen && !reset_seen && fifo_q.size() > 0) tmp = fifo_q.pop_front();
      #1;
      if (tx_busy) begin
        ff_if.r_data = ~ff_if.r_data;
        ff_if.empty  = 1'($urandom_range(0, 1));
      end else begin
        ff_if.empty  = (fifo_q.size() == 0);
        ff_if.r_data = (fifo_q.size() == 0) ? 8'($urandom) : fifo_q[0];
      end
    end
  end

  initial begin : monitor
    bit         in_frame   = 0;
    bit         reset_prev = 0;
    int         k = 0, bad = 0, first_bad = -1;
    int         last_rd = -100000, last_end = -1;
    logic [7:0] w = 8'h00;
    forever begin
      @(negedge clk);
      rd_seen    = ff_if.rd;
      reset_seen = reset;
      if (reset) begin
        if (ff_if.rd !== 1'b0) rd_in_reset++;
        if (reset_prev && (tx !== 1'b1 || tx_busy !== 1'b0)) reset_state_bad++;
        if (in_frame) aborted++;
        in_frame   = 0;
        reset_prev = 1;
      end else begin
        reset_prev = 0;
        if (in_frame) begin
          k++;
          if (k <= FRAME1) begin
            if (tx !== exp_tx(w, k) || tx_busy !== 1'b1) begin
              bad++;
              if (first_bad < 0) first_bad = k;
            end
            if (ff_if.rd !== 1'b0) spurious_rd++;
          end else begin
            n_cmp++;
            if (bad != 0) begin
              n_bad++;
              $display("FAIL frame_wave word=%02h: %0d bad cycles, first at offset %0d, expected 0", w, bad, first_bad);
            end
            chk("idle_reentry_busy", int'(tx_busy), 0);
            in_frame = 0;
            last_end = cyc;
            frames_done++;
          end
        end
        if (!in_frame) begin
          if (tx !== 1'b1 || tx_busy !== 1'b0) idle_bad++;
          if (ff_if.rd === 1'b1) begin
            if (ff_if.empty !== 1'b0 || exp_q.size() == 0) begin
              spurious_rd++;
            end else begin
              w = exp_q.pop_front();
              if (last_end == cyc) chk("b2b_rd_period", cyc - last_rd, FRAME1 + 1);
              last_rd   = cyc;
              in_frame  = 1;
              k         = 0;
              bad       = 0;
              first_bad = -1;
              rd_events++;
            end
          end else if (ff_if.empty === 1'b0) begin
            missed_rd++;
          end
        end
      end
    end
  end

  initial begin : dut2_check
    int bad = 0, stop_hi = 0;
    ff2_if.empty  = 1'b1;
    ff2_if.r_data = 8'h00;
    wait (reset == 1'b0);
    @(posedge clk);
    #1;
    ff2_if.empty  = 1'b0;
    ff2_if.r_data = 8'h55;
    @(negedge clk);
    chk("sb32_rd", int'(ff2_if.rd), 1);
    @(posedge clk);
    #1;
    ff2_if.empty = 1'b1;
    for (int k = 1; k <= FRAME2; k++) begin
      @(negedge clk);
      ff2_if.r_data = ~ff2_if.r_data;
      if (tx2 !== exp_tx(8'h55, k) || tx_busy2 !== 1'b1 || ff2_if.rd !== 1'b0) bad++;
      if (k > 9 * BITC && tx2 === 1'b1) stop_hi++;
    end
    @(negedge clk);
    chk("sb32_frame_bad_cycles", bad, 0);
    chk("sb32_stop_high_clocks", stop_hi, 32 * DVSR);
    chk("sb32_idle_at_T705", int'(tx_busy2), 0);
    chk("sb32_idle_tx", int'(tx2), 1);
    dut2_done = 1;
  end

  initial begin : stimulus
    int target;
    bit seen;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_rd", int'(ff_if.rd), 0);
    repeat (1000) @(posedge clk);

    push(8'hA5);
    wait_idle(3000);
    push(8'h00);
    push(8'hFF);
    wait_idle(3000);
    push(8'h3C);
    wait_idle(3000);

    // Abort 0x81 mid-DATA; 0x42 must follow as a clean frame.
    push(8'h81);
    push(8'h42);
    target = rd_events + 1;
    seen   = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (rd_events >= target) seen = 1;
    end
    if (!seen) chk("abort_rd_timeout", 0, 1);
    repeat (199) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_idle(3000);

    for (int n = 0; n < 20; n++) begin
      int words = $urandom_range(1, 3);
      for (int j = 0; j < words; j++) push(8'($urandom));
      repeat ($urandom_range(0, 1500)) @(posedge clk);
    end
    wait_idle(20000);

    for (int i = 0; i < 2000 && !dut2_done; i++) @(posedge clk);
    if (!dut2_done) chk("dut2_timeout", 0, 1);

    chk("missed_rd", missed_rd, 0);
    chk("spurious_rd", spurious_rd, 0);
    chk("idle_line_or_busy_bad", idle_bad, 0);
    chk("rd_during_reset", rd_in_reset, 0);
    chk("reset_state_bad", reset_state_bad, 0);
    chk("aborted_frames", aborted, 1);
    chk("scoreboard_leftover", exp_q.size(), 0);
    chk("frames_completed", frames_done, pushed - 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
